// File: rtl/hilo_pkg.sv
// Shared HI/LO unit definitions: op encodings, FSM states, divider control struct.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hilo_pkg;

   localparam int DATA_W    = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DIV  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   // Sign and divide-by-zero bookkeeping captured when a division is accepted.
   typedef struct packed {
      logic q_neg;   // quotient must be negated in FIX
      logic r_neg;   // remainder must be negated in FIX
      logic zero;    // divisor was zero: commit nothing
   } div_ctl_t;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v,
                                                input logic              neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider datapath: partial remainder, quotient shift, compare-subtract.
// Latency: one quotient bit per step edge; DIV_ITERS steps after load give the result.
// Backpressure: none; the controller sequences load/step and owns all stalling.
module div_iter
   import hilo_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dvs_q;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;
   logic              fits;

   // Shift the next dividend bit into the remainder and trial-subtract the divisor.
   // Remainder stays below the divisor, so 33 bits hold the shifted value exactly.
   always_comb begin
      shifted = {rem_q, quo_q[DATA_W-1]};
      diff    = shifted - {1'b0, dvs_q};
      fits    = ~diff[DATA_W];
   end

   // Quotient register doubles as the dividend shift register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         rem_q <= fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
         quo_q <= {quo_q[DATA_W-2:0], fits};
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: MULT/MULTU/MTHI/MTLO in one edge, DIV/DIVU via 32-step iterative divider.
// Latency: mult/move 1 edge; divide 34 edges (busy 33 cycles, done the cycle after). Option macro: HILO_BYPASS_EN.
// Backpressure: busy stalls the issuer; op_valid while busy or flush is dropped.
module hilo_unit
   import hilo_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              op_valid,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   div_ctl_t          ctl_q, ctl_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] hi_q, lo_q;
   logic              hi_we, lo_we;
   logic [DATA_W-1:0] hi_wd, lo_wd;

   logic              accept;
   logic              div_signed;
   logic              div_load;
   logic              div_step;
   logic [DATA_W-1:0] mag_a, mag_b;
   logic [DATA_W-1:0] quo, rem;
   logic [2*DATA_W-1:0] prod_s, prod_u;

   assign accept = op_valid && (state_q == ST_IDLE) && !flush;

   // Both products from one 64x64 truncated multiply each; low 64 bits are exact.
   always_comb begin
      prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
      prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
   end

   // Operand magnitudes fed to the unsigned divider core (signed DIV only).
   always_comb begin
      div_signed = (op_e'(op) == OP_DIV);
      mag_a      = mag32(src_a, div_signed & src_a[DATA_W-1]);
      mag_b      = mag32(src_b, div_signed & src_b[DATA_W-1]);
   end

   div_iter u_div_iter (
      .clk       (clk),
      .resetn    (resetn),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem)
   );

   // Next-state, iteration counting and HI/LO write selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ctl_d    = ctl_q;
      done_d   = 1'b0;
      hi_we    = 1'b0;
      lo_we    = 1'b0;
      hi_wd    = hi_q;
      lo_wd    = lo_q;
      div_load = 1'b0;
      div_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_e'(op))
                  OP_MULT: begin
                     hi_we = 1'b1;
                     lo_we = 1'b1;
                     {hi_wd, lo_wd} = prod_s;
                  end
                  OP_MULTU: begin
                     hi_we = 1'b1;
                     lo_we = 1'b1;
                     {hi_wd, lo_wd} = prod_u;
                  end
                  OP_MTHI: begin
                     hi_we = 1'b1;
                     hi_wd = src_a;
                  end
                  OP_MTLO: begin
                     lo_we = 1'b1;
                     lo_wd = src_a;
                  end
                  OP_DIV, OP_DIVU: begin
                     div_load    = 1'b1;
                     ctl_d.q_neg = div_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                     ctl_d.r_neg = div_signed & src_a[DATA_W-1];
                     ctl_d.zero  = (src_b == '0);
                     cnt_d       = '0;
                     state_d     = ST_DIV;
                  end
                  default: ;
               endcase
            end
         end

         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               div_step = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end

         ST_FIX: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (!flush) begin
               done_d = 1'b1;
               if (!ctl_q.zero) begin
                  hi_we = 1'b1;
                  lo_we = 1'b1;
                  lo_wd = ctl_q.q_neg ? (~quo + 32'd1) : quo;
                  hi_wd = ctl_q.r_neg ? (~rem + 32'd1) : rem;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control state: FSM, iteration counter, latched sign info, done pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ctl_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctl_q   <= ctl_d;
         done_q  <= done_d;
      end
   end

   // Architectural HI/LO registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (hi_we) hi_q <= hi_wd;
         if (lo_we) lo_q <= lo_wd;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

`ifdef HILO_BYPASS_EN
   // Single-cycle ops forward their write data in the accepting cycle; divide results do not.
   assign hi_out = (accept && hi_we) ? hi_wd : hi_q;
   assign lo_out = (accept && lo_we) ? lo_wd : lo_q;
`else
   assign hi_out = hi_q;
   assign lo_out = lo_q;
`endif

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- op_valid  in  1  an operation is presented this cycle.
- op  in  3  operation code: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception kill; aborts any in-flight division.
- busy  out  1  division in progress; the issuer SHALL stall on it.
- done  out  1  one-cycle pulse when a division commits.
- hi_out  out  32  architectural HI, feeding the write-back HI_wb path.
- lo_out  out  32  architectural LO, feeding the write-back LO_wb path.

Function
REQ-002 An operation SHALL be accepted on a rising edge where op_valid=1, busy=0 and flush=0; op_valid while busy=1 SHALL be ignored.
REQ-003 MULT/MULTU SHALL write the 64-bit signed/unsigned product {HI,LO}=src_a*src_b at the accepting edge (1-cycle latency).
REQ-004 MTHI SHALL write HI=src_a and MTLO SHALL write LO=src_a at the accepting edge, leaving the other register unchanged.
REQ-005 The FSM SHALL have states IDLE, DIV and FIX; busy SHALL be 1 exactly when the state is not IDLE.
REQ-006 DIV/DIVU acceptance at edge E0 SHALL latch the operand magnitudes and sign info, and move to DIV with iteration counter 0.
REQ-007 The DIV state SHALL perform one radix-2 restoring iteration per edge for 32 edges (E1..E32), then enter FIX.
REQ-008 The FIX state SHALL apply the signs at edge E33: quotient negated if sign(a)^sign(b), remainder negated if sign(a) (DIV only); it SHALL then write LO=quotient and HI=remainder, and return to IDLE.
REQ-009 busy SHALL be high for exactly 33 cycles, and done SHALL be high for the single cycle following E33.
REQ-010 Signed 0x80000000/0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-011 A zero divisor SHALL follow the identical 33-cycle timing, leave HI and LO unchanged, and still pulse done.
REQ-012 flush=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge, with HI/LO unchanged and no done pulse.
REQ-013 flush=1 in IDLE SHALL block acceptance of any op that cycle.

Reset
REQ-014 resetn=0 SHALL immediately force HI=0, LO=0, state=IDLE, counter=0, busy=0 and done=0, including during a division.
REQ-015 After resetn deasserts, the first op SHALL be acceptable at the first rising edge.

Configuration
REQ-016 With macro HILO_BYPASS_EN defined, hi_out/lo_out SHALL combinationally show the value being written by an MTHI/MTLO/MULT/MULTU accepted in the same cycle.
REQ-017 Without HILO_BYPASS_EN, hi_out/lo_out SHALL be the registered HI/LO only, so new values appear the cycle after the writing edge.

Structure
REQ-018 A shared package hilo_pkg SHALL hold the op encodings, the FSM state enum and the constant DIV_ITERS=32.
REQ-019 The iteration datapath (partial remainder, quotient shift, compare-subtract) SHALL be a sub-module div_iter, while FSM control and HI/LO storage stay in hilo_unit.

Verification
REQ-020 MULT 0xFFFFFFFF*0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE next cycle; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-021 DIV 0xFFFFFFF9(-7)/2 -> busy high 33 cycles, done in the following cycle, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-022 DIVU 100/7 -> LO=0x0000000E, HI=0x00000002; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-023 MTHI 0x12345678, then DIV started with flush at cycle 10 -> busy low the next cycle, HI=0x12345678 retained, no done.
REQ-024 DIVU 5/0 with HI=0xA, LO=0xB -> done after 33 busy cycles, HI=0xA, LO=0xB.
REQ-025 resetn low at cycle 20 of a DIV -> busy, done, HI and LO read 0 without waiting for a clock edge; a MULT 3*4 after release -> LO=0xC.
